// File: rtl/fir_out_decim_if.sv
// Stream bundle between the FIR output stage and its neighbours: FIR sample in, FIFO head out, status.
// No logic lives here; the DUT side uses the master modport, the environment the slave modport.
// Level width follows DEPTH so the occupancy can show the full count DEPTH.
interface fir_out_decim_if #(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic signed [17:0] i_y;
  logic               i_valid;
  logic        [15:0] o_data;
  logic               o_sat;
  logic               o_valid;
  logic               i_ready;
  logic [LVL_W-1:0]   o_level;
  logic [DROP_W-1:0]  o_drop_cnt;

  modport master (
    input  i_y, i_valid, i_ready,
    output o_data, o_sat, o_valid, o_level, o_drop_cnt
  );

  modport slave (
    output i_y, i_valid, i_ready,
    input  o_data, o_sat, o_valid, o_level, o_drop_cnt
  );
endinterface

// File: rtl/fir_out_decim.sv
// Keeps one of every DECIM FIR samples, saturates S(18,15) to S(16,15), buffers in a FWFT FIFO.
// Latency: 2 edges from the input sample edge to o_valid (stage-1 register, then FIFO write).
// Backpressure: none toward the FIR; a kept sample arriving at a full FIFO with no read is dropped and counted.
module fir_out_decim #(
  parameter int DECIM  = 4,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input logic             clk,
  input logic             i_rst,
  fir_out_decim_if.master bus
);
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [PH_W-1:0]   ph;
  logic              keep;
  logic [15:0]       sat_data;
  logic              sat_flag;
  logic [15:0]       s1_data;
  logic              s1_sat;
  logic              s1_vld;
  logic [16:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [DROP_W-1:0] drop_cnt;
  logic              not_empty;
  logic              full;
  logic              rd_en;
  logic              wr_en;
  logic              drop;

  assign keep = bus.i_valid && (ph == '0);

  // Phase counter: advances on every valid input sample, wraps at DECIM-1.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      ph <= '0;
    end else if (bus.i_valid) begin
      if (ph == PH_W'(DECIM - 1)) ph <= '0;
      else                        ph <= ph + PH_W'(1);
    end
  end

  // Clip to S(16,15): fractional bits line up, so only the top three bits decide overflow.
  always_comb begin
    sat_data = bus.i_y[15:0];
    sat_flag = 1'b0;
    if (!((bus.i_y[17:15] == 3'b000) || (bus.i_y[17:15] == 3'b111))) begin
      sat_flag = 1'b1;
      sat_data = bus.i_y[17] ? 16'h8000 : 16'h7FFF;
    end
  end

  // Stage-1 register: holds the saturated kept sample for one cycle.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      s1_data <= '0;
      s1_sat  <= 1'b0;
      s1_vld  <= 1'b0;
    end else begin
      s1_vld <= keep;
      if (keep) begin
        s1_data <= sat_data;
        s1_sat  <= sat_flag;
      end
    end
  end

  // A read at full frees a slot in the same cycle, so a concurrent write is accepted rather than dropped.
  assign not_empty = (level != '0);
  assign full      = (level == LVL_W'(DEPTH));
  assign rd_en     = not_empty && bus.i_ready;
  assign wr_en     = s1_vld && (!full || rd_en);
  assign drop      = s1_vld && full && !rd_en;

  // FIFO storage: contents need no reset since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s1_sat, s1_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Drop counter: counts samples lost to a full FIFO, sticks at all ones.
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  assign bus.o_valid    = not_empty;
  assign bus.o_data     = not_empty ? mem[rd_ptr][15:0] : 16'h0000;
  assign bus.o_sat      = not_empty ? mem[rd_ptr][16]   : 1'b0;
  assign bus.o_level    = level;
  assign bus.o_drop_cnt = drop_cnt;
endmodule

// File: tb/tb_fir_out_decim.sv
// Directed bench: a DECIM=4 instance for decimation/phase checks, a DECIM=1 instance for the rest.
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Saturation vectors are table-driven; overflow, full read/write and mid-run reset are hand sequences.
module tb_fir_out_decim;
  logic clk;
  logic i_rst;
  int   n_chk;
  int   n_pass;

  fir_out_decim_if #(.DEPTH(4), .DROP_W(8)) b1 ();
  fir_out_decim_if #(.DEPTH(4), .DROP_W(8)) b4 ();

  fir_out_decim #(.DECIM(1), .DEPTH(4), .DROP_W(8)) u_d1 (.clk(clk), .i_rst(i_rst), .bus(b1));
  fir_out_decim #(.DECIM(4), .DEPTH(4), .DROP_W(8)) u_d4 (.clk(clk), .i_rst(i_rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] y;
    logic [15:0] exp_data;
    logic        exp_sat;
  } sat_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sat_vec_t sv[8];
    n_chk  = 0;
    n_pass = 0;
    sv[0] = '{18'h08000, 16'h7FFF, 1'b1};
    sv[1] = '{18'h07FFF, 16'h7FFF, 1'b0};
    sv[2] = '{18'h37FFF, 16'h8000, 1'b1};
    sv[3] = '{18'h38000, 16'h8000, 1'b0};
    sv[4] = '{18'h00001, 16'h0001, 1'b0};
    sv[5] = '{18'h3FFFF, 16'hFFFF, 1'b0};
    sv[6] = '{18'h1FFFF, 16'h7FFF, 1'b1};
    sv[7] = '{18'h20000, 16'h8000, 1'b1};

    // Reset held with live input traffic
    i_rst = 1'b0;
    b1.i_valid = 1'b1; b1.i_ready = 1'b1; b1.i_y = '0;
    b4.i_valid = 1'b1; b4.i_ready = 1'b1; b4.i_y = '0;
    for (int k = 0; k < 3; k++) begin
      b1.i_y = 18'($urandom);
      b4.i_y = 18'($urandom);
      step();
      chk("rst_valid", 32'(b1.o_valid), 0);
      chk("rst_data", 32'(b1.o_data), 0);
      chk("rst_sat", 32'(b1.o_sat), 0);
      chk("rst_level", 32'(b1.o_level), 0);
      chk("rst_drop", 32'(b1.o_drop_cnt), 0);
      chk("rst_valid4", 32'(b4.o_valid), 0);
    end
    b1.i_valid = 1'b0;
    b4.i_valid = 1'b0;
    i_rst = 1'b1;
    step();

    // Decimation by 4 on a ramp: kept samples at edges 0,4,8,12 show up one edge later
    for (int k = 0; k < 20; k++) begin
      b4.i_valid = (k < 16);
      b4.i_y = 18'(k);
      step();
      chk("dec_valid", 32'(b4.o_valid), ((k % 4 == 1) && (k <= 13)) ? 1 : 0);
      if ((k % 4 == 1) && (k <= 13)) chk("dec_data", 32'(b4.o_data), 32'(k - 1));
    end
    b4.i_valid = 1'b0;

    // Saturation table on DECIM=1
    for (int i = 0; i < 8; i++) begin
      b1.i_y = sv[i].y;
      b1.i_valid = 1'b1;
      step();
      b1.i_valid = 1'b0;
      step();
      chk("sat_valid", 32'(b1.o_valid), 1);
      chk("sat_data", 32'(b1.o_data), 32'(sv[i].exp_data));
      chk("sat_flag", 32'(b1.o_sat), 32'(sv[i].exp_sat));
      step();
      chk("sat_empty", 32'(b1.o_valid), 0);
    end

    // Overflow: 6 samples into a 4-deep FIFO with no reads
    b1.i_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      b1.i_y = 18'(i);
      b1.i_valid = 1'b1;
      step();
    end
    b1.i_valid = 1'b0;
    step();
    chk("ovf_level", 32'(b1.o_level), 4);
    chk("ovf_drop", 32'(b1.o_drop_cnt), 2);
    b1.i_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_rd_valid", 32'(b1.o_valid), 1);
      chk("ovf_rd_data", 32'(b1.o_data), 32'(i));
      step();
    end
    chk("ovf_empty", 32'(b1.o_valid), 0);
    chk("ovf_level0", 32'(b1.o_level), 0);
    chk("ovf_drop_hold", 32'(b1.o_drop_cnt), 2);

    // Full FIFO with a read and a write at the same edge
    b1.i_ready = 1'b0;
    for (int i = 10; i <= 13; i++) begin
      b1.i_y = 18'(i);
      b1.i_valid = 1'b1;
      step();
    end
    b1.i_valid = 1'b0;
    step();
    chk("full_level", 32'(b1.o_level), 4);
    b1.i_y = 18'd14;
    b1.i_valid = 1'b1;
    step();
    b1.i_valid = 1'b0;
    b1.i_ready = 1'b1;
    step();
    chk("rw_level", 32'(b1.o_level), 4);
    chk("rw_drop", 32'(b1.o_drop_cnt), 2);
    for (int i = 11; i <= 14; i++) begin
      chk("rw_data", 32'(b1.o_data), 32'(i));
      step();
    end
    chk("rw_empty", 32'(b1.o_valid), 0);

    // Mid-operation reset: two stored entries plus one in stage 1; DECIM=4 phase left non-zero
    b1.i_ready = 1'b0;
    for (int i = 20; i <= 22; i++) begin
      b1.i_y = 18'(i);
      b1.i_valid = 1'b1;
      b4.i_y = 18'(i + 30);
      b4.i_valid = (i < 22);
      step();
    end
    b1.i_valid = 1'b0;
    b4.i_valid = 1'b0;
    chk("mid_level2", 32'(b1.o_level), 2);
    #2;
    i_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(b1.o_valid), 0);
    chk("mid_rst_level", 32'(b1.o_level), 0);
    chk("mid_rst_drop", 32'(b1.o_drop_cnt), 0);
    chk("mid_rst_data", 32'(b1.o_data), 0);
    #2;
    i_rst = 1'b1;
    step();
    chk("mid_no_stale", 32'(b1.o_valid), 0);
    step();
    chk("mid_no_stale2", 32'(b1.o_level), 0);
    b1.i_ready = 1'b1;
    b1.i_y = 18'd30;
    b1.i_valid = 1'b1;
    b4.i_y = 18'd60;
    b4.i_valid = 1'b1;
    step();
    b1.i_valid = 1'b0;
    b4.i_valid = 1'b0;
    step();
    chk("post_valid", 32'(b1.o_valid), 1);
    chk("post_data", 32'(b1.o_data), 30);
    chk("post_valid4", 32'(b4.o_valid), 1);
    chk("post_data4", 32'(b4.o_data), 60);
    step();
    chk("post_empty", 32'(b1.o_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
